// File: rtl/uart_pkg.sv
// Shared types for the UART parity engine: parity mode and RX check state.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_PAR  = 2'b10
  } rx_state_t;

endpackage

// File: rtl/uart_parity_expect.sv
// Expected parity bit from mode, XOR accumulator and enable.
// Mark/space modes exist only when UART_MARK_SPACE_EN is defined.
module uart_parity_expect
  import uart_pkg::*;
(
  input  par_mode_t mode,
  input  logic      acc,
  input  logic      par_en,
  output logic      exp_bit
);

`ifdef UART_MARK_SPACE_EN
  always_comb begin
    exp_bit = 1'b0;
    if (par_en) begin
      unique case (mode)
        PAR_EVEN:  exp_bit = acc;
        PAR_ODD:   exp_bit = ~acc;
        PAR_MARK:  exp_bit = 1'b1;
        PAR_SPACE: exp_bit = 1'b0;
        default:   exp_bit = 1'b0;
      endcase
    end
  end
`else
  // Without mark/space the upper mode bit is a don't-care: 10 acts as even, 11 as odd.
  logic unused_mode_hi;
  assign unused_mode_hi = mode[1];

  always_comb begin
    exp_bit = 1'b0;
    if (par_en) begin
      exp_bit = mode[0] ? ~acc : acc;
    end
  end
`endif

endmodule

// File: rtl/uart_parity_engine.sv
// UART parity engine: parallel TX parity generation and bit-serial RX parity check.
// Optional mark/space support is enabled by defining UART_MARK_SPACE_EN.
module uart_parity_engine
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        par_typ,
  input  logic              par_en,
  output logic              par_bit,
  output logic              par_vld,
  input  logic              rx_start,
  input  logic              rx_bit,
  input  logic              rx_stb,
  output logic              rx_busy,
  output logic              chk_done,
  output logic              par_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // TX path: parity of the loaded word, held until the next load
  par_mode_t tx_mode;
  logic      tx_acc;
  logic      tx_exp;

  assign tx_mode = par_mode_t'(par_typ);
  assign tx_acc  = ^tx_data;

  uart_parity_expect u_tx_expect (
    .mode    (tx_mode),
    .acc     (tx_acc),
    .par_en  (par_en),
    .exp_bit (tx_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
      par_vld <= 1'b0;
    end else if (tx_load) begin
      par_bit <= tx_exp;
      par_vld <= 1'b1;
    end
  end

  // RX path: mode latched at the start bit, data bits folded into acc
  rx_state_t        state, state_nxt;
  par_mode_t        rx_mode, rx_mode_nxt;
  logic             rx_en, rx_en_nxt;
  logic             acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt, err_nxt;
  logic             rx_exp;
  logic             last_data;

  uart_parity_expect u_rx_expect (
    .mode    (rx_mode),
    .acc     (acc),
    .par_en  (rx_en),
    .exp_bit (rx_exp)
  );

  assign last_data = (cnt == CNT_W'(DATA_W - 1));
  assign rx_busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    rx_mode_nxt = rx_mode;
    rx_en_nxt   = rx_en;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    // rx_start takes priority in every state and swallows a coincident strobe
    if (rx_start) begin
      state_nxt   = ST_DATA;
      rx_mode_nxt = par_mode_t'(par_typ);
      rx_en_nxt   = par_en;
      acc_nxt     = 1'b0;
      cnt_nxt     = '0;
    end else if (rx_stb) begin
      unique case (state)
        ST_DATA: begin
          acc_nxt = acc ^ rx_bit;
          cnt_nxt = (cnt == CNT_W'(DATA_W)) ? cnt : cnt + 1'b1;
          if (last_data) begin
            if (rx_en) begin
              state_nxt = ST_PAR;
            end else begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        ST_PAR: begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
          err_nxt   = (rx_bit != rx_exp);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rx_mode  <= PAR_EVEN;
      rx_en    <= 1'b0;
      acc      <= 1'b0;
      cnt      <= '0;
      chk_done <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rx_mode  <= rx_mode_nxt;
      rx_en    <= rx_en_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      chk_done <= done_nxt;
      par_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Directed plus randomized bench for uart_parity_engine, with DATA_W=8 and DATA_W=7 instances.
module tb_uart_parity_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_load;
  logic [7:0] tx_data;
  logic [1:0] par_typ;
  logic       par_en;
  logic       rx_start;
  logic       rx_bit;
  logic       rx_stb;

  logic d8_par_bit, d8_par_vld, d8_busy, d8_done, d8_err;
  logic d7_par_bit, d7_par_vld, d7_busy, d7_done, d7_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_parity_engine #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .tx_load(tx_load), .tx_data(tx_data),
    .par_typ(par_typ), .par_en(par_en), .par_bit(d8_par_bit), .par_vld(d8_par_vld),
    .rx_start(rx_start), .rx_bit(rx_bit), .rx_stb(rx_stb),
    .rx_busy(d8_busy), .chk_done(d8_done), .par_err(d8_err)
  );

  uart_parity_engine #(.DATA_W(7)) u_dut7 (
    .clk(clk), .rst(rst), .tx_load(tx_load), .tx_data(tx_data[6:0]),
    .par_typ(par_typ), .par_en(par_en), .par_bit(d7_par_bit), .par_vld(d7_par_vld),
    .rx_start(rx_start), .rx_bit(rx_bit), .rx_stb(rx_stb),
    .rx_busy(d7_busy), .chk_done(d7_done), .par_err(d7_err)
  );

  // Reference parity: count the ones, then apply the mode rule.
  function automatic logic ref_parity(input logic [7:0] d, input int n,
                                      input logic [1:0] typ, input logic en);
    int ones = 0;
    logic [1:0] eff;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
`ifdef UART_MARK_SPACE_EN
    eff = typ;
`else
    eff = {1'b0, typ[0]};
`endif
    if (!en) return 1'b0;
    case (eff)
      2'd0:    return (ones % 2) == 1;
      2'd1:    return (ones % 2) == 0;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input bit sel7);
    return sel7 ? d7_done : d8_done;
  endfunction

  function automatic logic err_of(input bit sel7);
    return sel7 ? d7_err : d8_err;
  endfunction

  function automatic logic busy_of(input bit sel7);
    return sel7 ? d7_busy : d8_busy;
  endfunction

  // One RX frame: start, nbits data strobes (LSB first), optional parity strobe, random gaps.
  task automatic rx_frame(input bit sel7, input logic [7:0] data, input int nbits,
                          input logic [1:0] typ, input logic en, input logic pbit,
                          input bit stb_on_start, input bit hold_idle);
    logic exp_err;
    int   total;
    int   k;
    exp_err  = en ? (pbit != ref_parity(data, nbits, typ, en)) : 1'b0;
    total    = en ? nbits + 1 : nbits;
    par_typ  = typ;
    par_en   = en;
    rx_start = 1'b1;
    if (stb_on_start) begin
      rx_stb = 1'b1;
      rx_bit = 1'b1;
    end
    tick();
    rx_start = 1'b0;
    rx_stb   = 1'b0;
    tx_load  = 1'b0;
    check("rx_busy_after_start", busy_of(sel7), 1'b1);
    check("no_done_after_start", done_of(sel7), 1'b0);
    par_typ = 2'($urandom_range(0, 3));
    par_en  = 1'($urandom_range(0, 1));
    for (k = 0; k < total; k++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("no_done_in_gap", done_of(sel7), 1'b0);
      end
      rx_stb = 1'b1;
      rx_bit = (k < nbits) ? data[k] : pbit;
      tick();
      rx_stb = 1'b0;
      rx_bit = 1'($urandom_range(0, 1));
      if (k != total - 1) check("no_early_done", done_of(sel7), 1'b0);
    end
    check("chk_done", done_of(sel7), 1'b1);
    check("par_err", err_of(sel7), exp_err);
    check("busy_falls_with_done", busy_of(sel7), 1'b0);
    if (hold_idle) begin
      tick();
      check("done_one_cycle", done_of(sel7), 1'b0);
      check("err_one_cycle", err_of(sel7), 1'b0);
    end
  endtask

  task automatic tx_step(input logic [7:0] d, input logic [1:0] typ, input logic en);
    tx_data = d;
    par_typ = typ;
    par_en  = en;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
    check("tx_par_bit8", d8_par_bit, ref_parity(d, 8, typ, en));
    check("tx_par_bit7", d7_par_bit, ref_parity(d, 7, typ, en));
    check("tx_par_vld", d8_par_vld, 1'b1);
  endtask

  initial begin
    logic [7:0] held_data;
    logic [1:0] held_typ;
    rst = 1'b1; tx_load = 1'b0; tx_data = '0; par_typ = '0; par_en = 1'b0;
    rx_start = 1'b0; rx_bit = 1'b0; rx_stb = 1'b0;
    tick();
    tick();
    check("rst_par_bit", d8_par_bit, 1'b0);
    check("rst_par_vld", d8_par_vld, 1'b0);
    check("rst_rx_busy", d8_busy, 1'b0);
    check("rst_chk_done", d8_done, 1'b0);
    check("rst_par_err", d8_err, 1'b0);
    rst = 1'b0;
    tick();
    check("par_vld_before_load", d8_par_vld, 1'b0);

    // TX: 8'hA5 under each mode, then parity disabled
    for (int t = 0; t < 4; t++) tx_step(8'hA5, 2'(t), 1'b1);
    tx_step(8'hA5, 2'b00, 1'b0);
    tx_step(8'h5A, 2'b01, 1'b1);
    held_data = 8'h5A;
    held_typ  = 2'b01;
    tx_data = 8'hFF; par_typ = 2'b00;
    tick();
    check("tx_hold_after_load", d8_par_bit, ref_parity(held_data, 8, held_typ, 1'b1));
    tx_step(8'h01, 2'b10, 1'b1);
    tx_step(8'h03, 2'b10, 1'b1);
    tx_step(8'h03, 2'b11, 1'b1);
    for (int i = 0; i < 12; i++)
      tx_step(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // RX stray strobes in IDLE
    for (int i = 0; i < 3; i++) begin
      rx_stb = 1'b1; rx_bit = 1'b1;
      tick();
      rx_stb = 1'b0;
      check("idle_stb_no_done", d8_done, 1'b0);
      check("idle_stb_not_busy", d8_busy, 1'b0);
    end

    // RX 8'h07 even with correct then wrong parity; TX load coincides with the first start
    tx_data = 8'hC3; par_typ = 2'b01; par_en = 1'b1; tx_load = 1'b1;
    rx_frame(1'b0, 8'h07, 8, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
    check("tx_with_rx_start", d8_par_bit, ref_parity(8'hC3, 8, 2'b00, 1'b1));
    rx_frame(1'b0, 8'h07, 8, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);

    // DATA_W=7, parity disabled
    rx_frame(1'b1, 8'h2D, 7, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Restart mid-frame, then a full valid frame
    par_typ = 2'b01; par_en = 1'b1; rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_stb = 1'b1; rx_bit = 1'b1;
      tick();
      rx_stb = 1'b0;
      check("restart_no_done", d8_done, 1'b0);
    end
    rx_frame(1'b0, 8'h07, 8, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset mid-frame
    par_typ = 2'b00; par_en = 1'b1; rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_stb = 1'b1; rx_bit = 1'b1;
      tick();
      rx_stb = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", d8_busy, 1'b0);
    check("midrst_done", d8_done, 1'b0);
    check("midrst_par_vld", d8_par_vld, 1'b0);
    check("midrst_par_bit", d8_par_bit, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rx_stb = 1'b1; rx_bit = 1'b0;
      tick();
      rx_stb = 1'b0;
      check("midrst_no_done", d8_done, 1'b0);
    end
    rx_frame(1'b0, 8'hB4, 8, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);

    // Strobe coincident with start is discarded
    rx_frame(1'b0, 8'h00, 8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);

    // Randomized frames, some back-to-back
    for (int i = 0; i < 16; i++)
      rx_frame(1'b0, 8'($urandom), 8, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++)
      rx_frame(1'b1, 8'($urandom), 7, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised parity unit for the UART datapath, the successor of the fixed 8-bit even/odd parity calculator. It generates the transmit parity bit from a parallel word and, independently, checks receive parity bit-serially against the sampled parity bit. Data width and parity mode are configurable, and the mode is latched per frame. It sits between the TX frame FSM/serializer and the RX sampler/deserializer.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_load  in  1  one-cycle strobe; captures tx_data, par_typ and par_en for a TX frame.
- tx_data  in  DATA_W  parallel TX word.
- par_typ  in  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
- par_en  in  1  parity enabled for the frame being started.
- par_bit  out  1  TX parity bit, registered and held until the next tx_load.
- par_vld  out  1  high from the cycle after tx_load until rst; qualifies par_bit.
- rx_start  in  1  one-cycle strobe at the RX start-bit edge; latches par_typ and par_en, clears the accumulator.
- rx_bit  in  1  sampled RX serial bit.
- rx_stb  in  1  rx_bit is valid this cycle (one strobe per data or parity bit).
- rx_busy  out  1  RX check in progress.
- chk_done  out  1  one-cycle pulse when the RX frame's parity check completes.
- par_err  out  1  one-cycle pulse coincident with chk_done on a parity mismatch.

## Operation
- Reset values: par_bit=0, par_vld=0, rx_busy=0, chk_done=0, par_err=0, RX FSM in IDLE, bit counter 0, accumulator 0.
- TX path, on tx_load:
  - par_en=0 gives par_bit=0.
  - Even gives par_bit = XOR of tx_data. Odd gives par_bit = XNOR of tx_data. Mark gives 1. Space gives 0.
  - tx_data may change after the load edge without affecting par_bit.
- RX FSM states:
  - IDLE: on rx_start, latch the mode, set acc=0 and cnt=0, go to DATA.
  - DATA: on each rx_stb, acc ^= rx_bit and cnt++. When the DATA_W-th strobe arrives, go to PAR if the latched par_en=1. Otherwise pulse chk_done with par_err=0 and return to IDLE.
  - PAR: on rx_stb, compare rx_bit with the expected bit (acc for even, ~acc for odd, 1 for mark, 0 for space). Pulse chk_done, pulse par_err if they differ, and return to IDLE.
- rx_busy=1 in DATA and PAR.
- rx_start in DATA or PAR restarts the frame: accumulator and counter are cleared and the mode is relatched. No chk_done is issued for the aborted frame.
- rx_start and rx_stb in the same cycle: rx_start wins and the strobe is discarded.
- Counter width is $clog2(DATA_W+1). The counter saturates at DATA_W and never wraps.
- The TX and RX paths are fully independent. tx_load and rx_start in the same cycle are both honoured.

## Timing
- TX latency: par_bit and par_vld are valid 1 cycle after tx_load.
- RX latency: chk_done and par_err assert in the cycle after the final relevant rx_stb edge, i.e. the parity-bit strobe, or the DATA_W-th strobe when parity is disabled. They are registered, last exactly 1 cycle, and rx_busy falls in the same cycle.
- Back-to-back frames: rx_start is accepted in the same cycle as chk_done.
- rst is asserted mid-frame: the engine is in IDLE next cycle with all outputs at their reset values, and the pending check is lost.
- rx_stb in IDLE is ignored.

## Configuration
- UART_MARK_SPACE_EN:
  - When defined, mark and space modes are supported as described above.
  - When undefined, par_typ[1] is ignored, so 10 behaves as even and 11 as odd, and the mark/space logic is not synthesised.

## Structure
- A shared package uart_pkg holds the parity mode typedef (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE) and the RX state typedef (ST_IDLE, ST_DATA, ST_PAR).
- One sub-module, uart_parity_expect, is a combinational function of (mode, acc, par_en) giving the expected parity bit. It is shared by the TX path (acc = reduction of tx_data) and the RX path.

## Test plan
- TX, DATA_W=8: tx_load with tx_data=8'hA5 under each mode -> par_bit is 0 (even), 1 (odd), 1 (mark), 0 (space), one cycle later; par_en=0 -> par_bit=0.
- RX, DATA_W=8: rx_start, then bits of 8'h07 LSB-first, then parity bit 1, even mode -> chk_done with par_err=0. Repeating with parity bit 0 -> par_err=1.
- RX, DATA_W=7, par_en=0: rx_start plus 7 strobes -> chk_done one cycle after the 7th strobe, par_err=0, no parity bit consumed.
- RX restart: rx_start, 4 strobes, rx_start again, then a full valid frame -> exactly one chk_done with par_err=0.
- RX reset mid-frame: rx_start, 3 strobes, rst for 1 cycle -> rx_busy=0 and no chk_done. A following frame checks correctly.
- Macro off: par_typ=2'b10 with tx_data=8'h01 -> par_bit=1 (even behaviour). Macro on -> par_bit=1 (mark). With tx_data=8'h03 the results are 0 (off) and 1 (on).
